// File: rtl/spice_relax_sequencer.sv
// Relaxation sequencer for the switch-level node network: sweeps all nodes,
// writes back saturated v+i, and repeats until settled or the sweep cap is hit.
module spice_relax_sequencer #(
    parameter int W         = 16,
    parameter int AW        = 8,
    parameter int NUM_NODES = 200,
    parameter int MIN_ITERS = 4,
    parameter int MAX_ITERS = 32,
    parameter int EPS       = 16
) (
    input  logic          eclk,
    input  logic          ereset,
    input  logic          step_req,
    output logic          step_ack,
    output logic          busy,
    output logic          rd_en,
    output logic [AW-1:0] rd_addr,
    input  logic [W-1:0]  rd_v,
    input  logic [W-1:0]  rd_i,
    output logic          wr_en,
    output logic [AW-1:0] wr_addr,
    output logic [W-1:0]  wr_v,
    output logic [7:0]    iter_count,
    output logic          converged,
    output logic          timeout
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SWEEP,
        S_DRAIN,
        S_CHECK,
        S_DONE
    } state_t;

    localparam logic [AW-1:0] LAST_ADDR = AW'(NUM_NODES - 1);
    localparam logic [7:0]    MIN_IT    = 8'(MIN_ITERS);
    localparam logic [7:0]    MAX_IT    = 8'(MAX_ITERS);
    localparam logic [W-1:0]  EPS_V     = W'(EPS);
    localparam logic [W-1:0]  POS_MAX   = {1'b0, {(W-1){1'b1}}};
    localparam logic [W-1:0]  NEG_MIN   = {1'b1, {(W-1){1'b0}}};

    state_t        state_q, state_d;
    logic [AW-1:0] addr_q, addr_d;
    logic          wr_valid_q, wr_valid_d;
    logic [AW-1:0] wr_addr_q, wr_addr_d;
    logic [W-1:0]  max_q, max_d;
    logic [7:0]    iter_q, iter_d;
    logic          conv_q, conv_d;
    logic          tmo_q, tmo_d;

    logic [W:0]    sum;
    logic [W-1:0]  sat_v;
    logic [W-1:0]  mag;
    logic [7:0]    iter_inc;

    // Overflow is visible as disagreement between the two top bits of the widened sum.
    always_comb begin
        sum = {rd_v[W-1], rd_v} + {rd_i[W-1], rd_i};
        if (sum[W] != sum[W-1]) begin
            sat_v = sum[W] ? NEG_MIN : POS_MAX;
        end else begin
            sat_v = sum[W-1:0];
        end
        if (rd_i == NEG_MIN) begin
            mag = POS_MAX;
        end else if (rd_i[W-1]) begin
            mag = ~rd_i + 1'b1;
        end else begin
            mag = rd_i;
        end
    end

    always_ff @(posedge eclk or posedge ereset) begin
        if (ereset) begin
            state_q    <= S_IDLE;
            addr_q     <= '0;
            wr_valid_q <= 1'b0;
            wr_addr_q  <= '0;
            max_q      <= '0;
            iter_q     <= '0;
            conv_q     <= 1'b0;
            tmo_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            wr_valid_q <= wr_valid_d;
            wr_addr_q  <= wr_addr_d;
            max_q      <= max_d;
            iter_q     <= iter_d;
            conv_q     <= conv_d;
            tmo_q      <= tmo_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        wr_valid_d = (state_q == S_SWEEP);
        wr_addr_d  = addr_q;
        max_d      = max_q;
        iter_d     = iter_q;
        conv_d     = conv_q;
        tmo_d      = tmo_q;
        iter_inc   = iter_q + 8'd1;

        if (wr_valid_q && (mag > max_q)) begin
            max_d = mag;
        end

        case (state_q)
            S_IDLE: begin
                if (step_req) begin
                    state_d = S_SWEEP;
                    addr_d  = '0;
                    max_d   = '0;
                    iter_d  = '0;
                    conv_d  = 1'b0;
                    tmo_d   = 1'b0;
                end
            end
            S_SWEEP: begin
                if (addr_q == LAST_ADDR) begin
                    state_d = S_DRAIN;
                    addr_d  = '0;
                end else begin
                    addr_d  = addr_q + 1'b1;
                end
            end
            S_DRAIN: begin
                state_d = S_CHECK;
            end
            S_CHECK: begin
                iter_d = iter_inc;
                // Convergence is tested first so it wins when the cap is also reached.
                if ((iter_inc >= MIN_IT) && (max_q < EPS_V)) begin
                    conv_d  = 1'b1;
                    state_d = S_DONE;
                end else if (iter_inc == MAX_IT) begin
                    tmo_d   = 1'b1;
                    state_d = S_DONE;
                end else begin
                    max_d   = '0;
                    addr_d  = '0;
                    state_d = S_SWEEP;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign step_ack   = (state_q == S_DONE);
    assign busy       = (state_q != S_IDLE);
    assign rd_en      = (state_q == S_SWEEP);
    assign rd_addr    = addr_q;
    assign wr_en      = wr_valid_q;
    assign wr_addr    = wr_addr_q;
    assign wr_v       = wr_valid_q ? sat_v : '0;
    assign iter_count = iter_q;
    assign converged  = conv_q;
    assign timeout    = tmo_q;

endmodule

// File: tb/tb_spice_relax_sequencer.sv
// Directed bench for spice_relax_sequencer on a 4-node network with a small node RAM model.
module tb_spice_relax_sequencer;

    logic               clk = 1'b0;
    logic               rst;
    logic               step_req;
    logic               step_ack, busy, rd_en, wr_en, converged, timeout;
    logic [7:0]         rd_addr, wr_addr, iter_count;
    logic signed [15:0] rd_v, rd_i, wr_v;

    logic signed [15:0] mem [4];
    logic signed [15:0] cur [4];
    logic signed [15:0] init_v [4];
    logic               init_req;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    spice_relax_sequencer #(
        .W(16), .AW(8), .NUM_NODES(4), .MIN_ITERS(2), .MAX_ITERS(4), .EPS(16)
    ) dut (
        .eclk(clk), .ereset(rst), .step_req(step_req), .step_ack(step_ack),
        .busy(busy), .rd_en(rd_en), .rd_addr(rd_addr), .rd_v(rd_v), .rd_i(rd_i),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_v(wr_v), .iter_count(iter_count),
        .converged(converged), .timeout(timeout)
    );

    // Node RAM and current source: read data valid one cycle after rd_en.
    always @(posedge clk) begin
        if (init_req) begin
            for (int i = 0; i < 4; i++) mem[i] <= init_v[i];
        end else if (wr_en) begin
            mem[wr_addr[1:0]] <= wr_v;
        end
        if (rd_en) begin
            rd_v <= mem[rd_addr[1:0]];
            rd_i <= cur[rd_addr[1:0]];
        end
    end

    task automatic load(input logic signed [15:0] v0, v1, v2, v3,
                        input logic signed [15:0] c0, c1, c2, c3);
        @(negedge clk);
        init_v[0] = v0; init_v[1] = v1; init_v[2] = v2; init_v[3] = v3;
        cur[0] = c0; cur[1] = c1; cur[2] = c2; cur[3] = c3;
        init_req = 1'b1;
        @(negedge clk);
        init_req = 1'b0;
    endtask

    // Pulse step_req; cyc is 1 in the cycle after acceptance and counts to step_ack.
    task automatic run_step(output int cyc);
        @(negedge clk) step_req = 1'b1;
        @(negedge clk) step_req = 1'b0;
        cyc = 1;
        while (step_ack !== 1'b1 && cyc < 100) begin
            @(negedge clk);
            cyc++;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; step_req = 1'b0; init_req = 1'b0;
        for (int i = 0; i < 4; i++) begin init_v[i] = '0; cur[i] = '0; end
        repeat (2) @(negedge clk);
        n_cmp++;
        if ({step_ack, busy, rd_en, rd_addr, wr_en, wr_addr, wr_v, iter_count, converged, timeout} !== '0) begin
            n_bad++;
            $display("FAIL reset_outputs: busy=%b rd_en=%b wr_en=%b iter=%0d conv=%b tmo=%b, required all zero",
                     busy, rd_en, wr_en, iter_count, converged, timeout);
        end
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_converge();
        int cyc;
        load(0, 0, 0, 0, 0, 0, 0, 0);
        @(negedge clk) step_req = 1'b1;
        @(negedge clk) step_req = 1'b0;
        cyc = 1;
        for (int c = 1; c <= 6; c++) begin
            n_cmp++;
            if (rd_en !== (c <= 4) || (c <= 4 && rd_addr !== 8'(c - 1))) begin
                n_bad++;
                $display("FAIL read_seq c=%0d: rd_en=%b rd_addr=%0d, required rd_en=%b rd_addr=%0d",
                         c, rd_en, rd_addr, (c <= 4), c - 1);
            end
            n_cmp++;
            if (wr_en !== (c >= 2 && c <= 5) || (c >= 2 && c <= 5 && (wr_addr !== 8'(c - 2) || wr_v !== 16'sd0))) begin
                n_bad++;
                $display("FAIL write_seq c=%0d: wr_en=%b wr_addr=%0d wr_v=%0d, required wr_en=%b wr_addr=%0d wr_v=0",
                         c, wr_en, wr_addr, wr_v, (c >= 2 && c <= 5), c - 2);
            end
            @(negedge clk);
            cyc++;
        end
        while (step_ack !== 1'b1 && cyc < 100) begin
            @(negedge clk);
            cyc++;
        end
        n_cmp++;
        if (cyc !== 13) begin
            n_bad++; $display("FAIL conv_latency: %0d cycles, required 13", cyc);
        end
        n_cmp++;
        if ({converged, timeout, iter_count} !== {1'b1, 1'b0, 8'd2}) begin
            n_bad++;
            $display("FAIL conv_status: conv=%b tmo=%b iter=%0d, required conv=1 tmo=0 iter=2", converged, timeout, iter_count);
        end
        @(negedge clk);
        n_cmp++;
        if (step_ack !== 1'b0 || busy !== 1'b0) begin
            n_bad++; $display("FAIL ack_one_cycle: ack=%b busy=%b, required ack=0 busy=0", step_ack, busy);
        end
    endtask

    task automatic test_timeout();
        int cyc;
        load(0, 0, 0, 0, 100, 100, 100, 100);
        run_step(cyc);
        n_cmp++;
        if (cyc !== 25) begin
            n_bad++; $display("FAIL tmo_latency: %0d cycles, required 25", cyc);
        end
        n_cmp++;
        if ({converged, timeout, iter_count} !== {1'b0, 1'b1, 8'd4}) begin
            n_bad++;
            $display("FAIL tmo_status: conv=%b tmo=%b iter=%0d, required conv=0 tmo=1 iter=4", converged, timeout, iter_count);
        end
        @(negedge clk);
        for (int i = 0; i < 4; i++) begin
            n_cmp++;
            if (mem[i] !== 16'sd400) begin
                n_bad++; $display("FAIL tmo_node%0d: v=%0d, required 400", i, mem[i]);
            end
        end
    endtask

    task automatic test_saturation();
        int cyc;
        logic signed [15:0] exp_v [4];
        exp_v[0] = 16'sd32767; exp_v[1] = -16'sd32768; exp_v[2] = -16'sd32768; exp_v[3] = 16'sd5;
        load(16'sd32000, -16'sd32000, 16'sd0, 16'sd5, 16'sd1000, -16'sd1000, -16'sd32768, 16'sd0);
        @(negedge clk) step_req = 1'b1;
        @(negedge clk) step_req = 1'b0;
        cyc = 1;
        while (cyc < 6) begin
            if (cyc >= 2) begin
                n_cmp++;
                if (wr_en !== 1'b1 || wr_v !== exp_v[cyc - 2]) begin
                    n_bad++;
                    $display("FAIL sat_wr_node%0d: wr_en=%b wr_v=%0d, required wr_en=1 wr_v=%0d",
                             cyc - 2, wr_en, wr_v, exp_v[cyc - 2]);
                end
            end
            @(negedge clk);
            cyc++;
        end
        while (step_ack !== 1'b1 && cyc < 100) begin
            @(negedge clk);
            cyc++;
        end
        n_cmp++;
        if (cyc !== 25 || {converged, timeout, iter_count} !== {1'b0, 1'b1, 8'd4}) begin
            n_bad++;
            $display("FAIL sat_status: cyc=%0d conv=%b tmo=%b iter=%0d, required cyc=25 conv=0 tmo=1 iter=4",
                     cyc, converged, timeout, iter_count);
        end
        @(negedge clk);
        for (int i = 0; i < 4; i++) begin
            n_cmp++;
            if (mem[i] !== exp_v[i]) begin
                n_bad++; $display("FAIL sat_node%0d: v=%0d, required %0d", i, mem[i], exp_v[i]);
            end
        end
    endtask

    task automatic test_eps_boundary();
        int cyc;
        load(0, 0, 0, 0, 15, -15, 15, 0);
        run_step(cyc);
        n_cmp++;
        if (cyc !== 13 || {converged, timeout, iter_count} !== {1'b1, 1'b0, 8'd2}) begin
            n_bad++;
            $display("FAIL eps_below: cyc=%0d conv=%b tmo=%b iter=%0d, required cyc=13 conv=1 tmo=0 iter=2",
                     cyc, converged, timeout, iter_count);
        end
        @(negedge clk);
        n_cmp++;
        if (mem[1] !== -16'sd30) begin
            n_bad++; $display("FAIL eps_below_node1: v=%0d, required -30", mem[1]);
        end
        load(0, 0, 0, 0, 0, -16, 0, 0);
        run_step(cyc);
        n_cmp++;
        if (cyc !== 25 || {converged, timeout, iter_count} !== {1'b0, 1'b1, 8'd4}) begin
            n_bad++;
            $display("FAIL eps_equal: cyc=%0d conv=%b tmo=%b iter=%0d, required cyc=25 conv=0 tmo=1 iter=4",
                     cyc, converged, timeout, iter_count);
        end
        @(negedge clk);
    endtask

    task automatic test_reset_mid_sweep();
        int cyc;
        load(0, 0, 0, 0, 0, 0, 0, 0);
        @(negedge clk) step_req = 1'b1;
        @(negedge clk) step_req = 1'b0;
        repeat (2) @(negedge clk);
        n_cmp++;
        if (rd_en !== 1'b1 || rd_addr !== 8'd2) begin
            n_bad++; $display("FAIL mid_pre_reset: rd_en=%b rd_addr=%0d, required rd_en=1 rd_addr=2", rd_en, rd_addr);
        end
        rst = 1'b1;
        #1;
        n_cmp++;
        if ({step_ack, busy, rd_en, rd_addr, wr_en, wr_addr, wr_v, iter_count, converged, timeout} !== '0) begin
            n_bad++;
            $display("FAIL mid_reset_outputs: busy=%b rd_en=%b rd_addr=%0d wr_en=%b iter=%0d conv=%b, required all zero",
                     busy, rd_en, rd_addr, wr_en, iter_count, converged);
        end
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            n_cmp++;
            if (wr_en !== 1'b0 || busy !== 1'b0) begin
                n_bad++; $display("FAIL mid_reset_hold%0d: wr_en=%b busy=%b, required 0 0", k, wr_en, busy);
            end
        end
        rst = 1'b0;
        @(negedge clk) step_req = 1'b1;
        @(negedge clk) step_req = 1'b0;
        n_cmp++;
        if (rd_en !== 1'b1 || rd_addr !== 8'd0 || iter_count !== 8'd0) begin
            n_bad++;
            $display("FAIL mid_restart: rd_en=%b rd_addr=%0d iter=%0d, required 1 0 0", rd_en, rd_addr, iter_count);
        end
        cyc = 1;
        while (step_ack !== 1'b1 && cyc < 100) begin
            @(negedge clk);
            cyc++;
        end
        n_cmp++;
        if (cyc !== 13 || converged !== 1'b1) begin
            n_bad++; $display("FAIL mid_restart_done: cyc=%0d conv=%b, required 13 1", cyc, converged);
        end
        @(negedge clk);
    endtask

    task automatic test_back_to_back();
        int cyc;
        int acks;
        load(0, 0, 0, 0, 0, 0, 0, 0);
        @(negedge clk) step_req = 1'b1;
        @(negedge clk);
        cyc = 1;
        while (step_ack !== 1'b1 && cyc < 100) begin
            @(negedge clk);
            cyc++;
        end
        n_cmp++;
        if (cyc !== 13) begin
            n_bad++; $display("FAIL b2b_first: %0d cycles, required 13", cyc);
        end
        @(negedge clk);
        n_cmp++;
        if (busy !== 1'b0 || step_ack !== 1'b0) begin
            n_bad++; $display("FAIL b2b_idle_gap: busy=%b ack=%b, required 0 0", busy, step_ack);
        end
        @(negedge clk);
        n_cmp++;
        if (busy !== 1'b1 || rd_en !== 1'b1 || rd_addr !== 8'd0) begin
            n_bad++; $display("FAIL b2b_restart: busy=%b rd_en=%b rd_addr=%0d, required 1 1 0", busy, rd_en, rd_addr);
        end
        step_req = 1'b0;
        acks = 0;
        for (int c = 2; c <= 30; c++) begin
            @(negedge clk);
            step_req = (c == 4 || c == 6 || c == 9);
            if (step_ack === 1'b1) acks++;
        end
        step_req = 1'b0;
        n_cmp++;
        if (acks !== 1 || busy !== 1'b0) begin
            n_bad++; $display("FAIL busy_pulses: acks=%0d busy=%b, required acks=1 busy=0", acks, busy);
        end
    endtask

    initial begin
        test_reset();
        test_converge();
        test_timeout();
        test_saturation();
        test_eps_boundary();
        test_reset_mid_sweep();
        test_back_to_back();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/spice_relax_sequencer.md
Name: spice_relax_sequencer

Overview:
Sequences time-multiplexed relaxation of the switch-level node network. On each step request it sweeps every node address, reads the node voltage and its summed transistor/pullup current, and writes back the saturated updated voltage. Sweeps repeat until the network settles or an iteration cap is reached, then the step is acknowledged. It sits between the emulated-clock phase generator (requester) and the node-voltage RAM plus current-summing datapath.

Parameters:
W, 16, signed voltage/current width (matches codebase `W)
AW, 8, node address width
NUM_NODES, 200, node count; addresses 0..NUM_NODES-1; 2 ≤ NUM_NODES ≤ 2^AW
MIN_ITERS, 4, minimum sweeps before convergence may be declared; ≥1
MAX_ITERS, 32, sweep cap per step; MIN_ITERS ≤ MAX_ITERS ≤ 255
EPS, 16, convergence threshold on max |current| per sweep (unsigned, < 2^(W-1))

Ports:
eclk  in  1  clock
ereset  in  1  reset, asynchronous, active-high
step_req  in  1  level request to run one settle step; sampled only in IDLE
step_ack  out  1  one-cycle pulse: step complete
busy  out  1  high in every state except IDLE
rd_en  out  1  node read strobe
rd_addr  out  AW  node read address
rd_v  in  W  signed node voltage, valid 1 cycle after rd_en
rd_i  in  W  signed net node current, valid 1 cycle after rd_en
wr_en  out  1  node write strobe
wr_addr  out  AW  node write address
wr_v  out  W  signed updated voltage
iter_count  out  8  sweeps completed in current/last step
converged  out  1  last step ended by convergence
timeout  out  1  last step ended by hitting MAX_ITERS

Behaviour:
- Reset (async, ereset=1): FSM=IDLE; all outputs 0; internal address, pipeline valid, max-delta cleared. No wr_en may be asserted after the reset edge, even mid-sweep; partially swept nodes keep whatever was written.
- States: IDLE, SWEEP, DRAIN, CHECK, DONE.
- IDLE: step_req=1 -> SWEEP; iter_count, converged, timeout cleared that edge; read address=0; max-delta=0.
- SWEEP: rd_en=1, rd_addr = 0,1,...,NUM_NODES-1 on consecutive cycles; after issuing NUM_NODES-1 -> DRAIN.
- Write pipeline: one cycle after each read, wr_en=1, wr_addr = previous rd_addr, wr_v = sat(rd_v + rd_i). Sum computed at W+1 bits; clamp to [-2^(W-1), 2^(W-1)-1].
- Magnitude: |rd_i| computed per written node; -2^(W-1) maps to 2^(W-1)-1. max-delta = running max over the sweep.
- DRAIN: rd_en=0; last write (node NUM_NODES-1) occurs this cycle -> CHECK.
- CHECK: iter_count increments. If iter_count(new) ≥ MIN_ITERS and max-delta < EPS: converged=1 -> DONE. Else if iter_count(new) = MAX_ITERS: timeout=1 -> DONE. Else max-delta=0, address=0 -> SWEEP. Convergence has priority when both conditions hold.
- DONE: step_ack=1 for exactly one cycle -> IDLE. converged/timeout/iter_count hold until next accepted step_req.
- Per-sweep cost NUM_NODES+2 cycles; step latency from step_req acceptance to step_ack = n*(NUM_NODES+2)+1 cycles, n = sweeps run.
- step_req outside IDLE ignored (no queuing); if still high in IDLE after DONE, a new step starts the next cycle.
- rd_en and wr_en may both be high in the same cycle at different addresses; the RAM provides write-first-independent dual ports.

Test Plan:
- NUM_NODES=4, MIN_ITERS=2, rd_i always 0, step_req pulse -> rd_addr 0,1,2,3; wr_addr 0..3 one cycle later; converged=1, iter_count=2, step_ack exactly 2*(4+2)+1=13 cycles after acceptance.
- rd_i constant 100, EPS=16, MAX_ITERS=3 -> three sweeps, timeout=1, converged=0, iter_count=3; each node's wr_v increases by 100 per sweep.
- Saturation: rd_v=32000, rd_i=1000 (W=16) -> wr_v=32767; rd_v=-32000, rd_i=-1000 -> wr_v=-32768; rd_i=-32768 counts as magnitude 32767 (no convergence).
- rd_i=50 in sweep 1, 0 thereafter, MIN_ITERS=4 -> converged at iter_count=4, not earlier despite sweep 2 meeting EPS.
- Assert ereset mid-SWEEP at node 2 -> same-cycle all outputs 0, no further wr_en; after release and a new step_req, sweep restarts at address 0 with iter_count=0.
- step_req held high continuously -> back-to-back steps separated by exactly one IDLE cycle; pulses of step_req while busy produce no extra step_ack.
